// File: rtl/sincos_requester_if.sv
// Handshake bundle between the angle source, the sincos engine and the
// result consumer; the requester sits on the slave side.
interface sincos_requester_if;
    logic        in_valid;
    logic [31:0] in_opx;
    logic        in_ready;
    logic        sine_start;
    logic [31:0] opx;
    logic        sine_done;
    logic [31:0] sine_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_err;
    logic        busy;
    logic [7:0]  err_count;

    modport slave (
        input  in_valid, in_opx, sine_done, sine_result, out_ready,
        output in_ready, sine_start, opx, out_valid, out_result,
        output out_err, busy, err_count
    );

    modport master (
        output in_valid, in_opx, sine_done, sine_result, out_ready,
        input  in_ready, sine_start, opx, out_valid, out_result,
        input  out_err, busy, err_count
    );
endinterface

// File: rtl/sincos_requester.sv
// Single-outstanding request sequencer for a sincos engine, with a
// timeout watchdog and a result FIFO whose space is reserved at accept.
module sincos_requester #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    sincos_requester_if.slave io
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]   QNAN   = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [31:0]   opx_q;
    logic [7:0]    err_q;

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic          accept;
    logic          push;
    logic          push_err;
    logic          pop;
    logic          start;
    logic [31:0]   push_data;

    assign io.in_ready = (state == IDLE) && (count < FULL) && !rst;
    assign accept      = io.in_valid && io.in_ready;
    assign io.out_valid = (count != '0);
    assign pop          = io.out_valid && io.out_ready;

    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        push      = 1'b0;
        push_err  = 1'b0;
        push_data = io.sine_result;
        start     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = ISSUE;
            end
            ISSUE: begin
                start    = 1'b1;
                timer_nx = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                // completion takes priority over an expiring watchdog
                if (io.sine_done) begin
                    push     = 1'b1;
                    state_nx = IDLE;
                end else if (timer == T_LAST) begin
                    push      = 1'b1;
                    push_err  = 1'b1;
                    push_data = QNAN;
                    state_nx  = IDLE;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            opx_q <= '0;
            err_q <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            if (accept) opx_q <= io.in_opx;
            if (push_err && err_q != 8'hFF) err_q <= err_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_err, push_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign io.sine_start = start;
    assign io.opx        = opx_q;
    assign io.busy       = (state != IDLE);
    assign io.err_count  = err_q;
    assign io.out_result = io.out_valid ? mem[rd_ptr][31:0] : '0;
    assign io.out_err    = io.out_valid ? mem[rd_ptr][32] : 1'b0;
endmodule

// File: tb/tb_sincos_requester.sv
// Scoreboard bench: jobs carry the engine behaviour chosen per request,
// expected FIFO entries are derived from the timeout rule at accept time.
module tb_sincos_requester;
    localparam int TO = 64;

    typedef struct {
        logic [31:0] opx;
        int          dly;
        logic [31:0] res;
    } job_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sincos_requester_if bus ();

    sincos_requester #(.DEPTH(4), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    job_t        jobs[$];
    logic [32:0] sb[$];
    int vecs     = 0;
    int errs     = 0;
    int n_to     = 0;
    int rdy_mode = 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        vecs++;
        errs++;
        $display("FAIL %s: got timeout, expected event", name);
    endtask

    // caller is at posedge+1; returns at posedge+1 of the ISSUE cycle
    task automatic send(input logic [31:0] a, input int d,
                        input logic [31:0] r, input bit expect_out);
        job_t j;
        int   n;
        bit   ok;
        j.opx = a;
        j.dly = d;
        j.res = r;
        bus.in_valid = 1'b1;
        bus.in_opx   = a;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 400) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            miss("accept");
        end else begin
            jobs.push_back(j);
            if (expect_out) begin
                if (d >= 1 && d <= TO) begin
                    sb.push_back({1'b0, r});
                end else begin
                    sb.push_back({1'b1, 32'h7FC0_0000});
                    n_to++;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_opx   = $urandom;
    endtask

    // engine model
    initial begin
        job_t j;
        bus.sine_done   = 1'b0;
        bus.sine_result = '0;
        forever begin
            @(negedge clk);
            if (bus.sine_start) begin
                if (jobs.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL start: got pulse, expected none");
                end else begin
                    j = jobs.pop_front();
                    chk("opx", 64'(bus.opx), 64'(j.opx));
                    if (j.dly > 0) begin
                        repeat (j.dly) @(posedge clk);
                        #1;
                        bus.sine_done   = 1'b1;
                        bus.sine_result = j.res;
                        @(posedge clk);
                        #1;
                        bus.sine_done   = 1'b0;
                        bus.sine_result = $urandom;
                    end
                end
            end
        end
    end

    // one-cycle start pulse and operand hold while busy
    initial begin
        logic        prev_start;
        logic [31:0] held;
        prev_start = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (bus.sine_start) begin
                chk("start_pulse", 64'(prev_start), 64'd0);
                held = bus.opx;
            end else if (bus.busy) begin
                chk("opx_hold", 64'(bus.opx), 64'(held));
            end
            prev_start = bus.sine_start;
        end
    end

    // output monitor
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL extra_out: got %h, expected none",
                             {bus.out_err, bus.out_result});
                end else begin
                    e = sb.pop_front();
                    chk("out", 64'({bus.out_err, bus.out_result}), 64'(e));
                end
            end
        end
    end

    // downstream ready: 0 low, 1 high, otherwise random
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        int          n;
        int          r;
        int          d;
        logic [31:0] a;
        bus.in_valid = 1'b0;
        bus.in_opx   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_start", 64'(bus.sine_start), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out", 64'({bus.out_err, bus.out_result}), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_err_count", 64'(bus.err_count), 64'd0);
        chk("rst_opx", 64'(bus.opx), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // abandon a request with reset; its late completion is ignored
        send(32'h1111_1111, 10, 32'h0000_DEAD, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("rstw_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rstw_busy", 64'(bus.busy), 64'd0);
        chk("rstw_err_count", 64'(bus.err_count), 64'd0);
        @(posedge clk);
        #1;

        // single request latency
        send(32'h3FC9_0FDB, 4, 32'h3F80_0000, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("lat_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;

        // timeout with a late completion, then done/timeout collision
        send(32'h4049_0FDB, TO + 1, 32'h1234_5678, 1'b1);
        repeat (80) @(posedge clk);
        @(negedge clk);
        chk("to_err_count", 64'(bus.err_count), 64'(n_to));
        @(posedge clk);
        #1;
        send(32'h3F06_0A92, TO, 32'h3F00_0000, 1'b1);
        repeat (70) @(posedge clk);
        @(negedge clk);
        chk("coll_err_count", 64'(bus.err_count), 64'(n_to));
        @(posedge clk);
        #1;

        // fill the FIFO with the consumer stalled
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) send($urandom, 3, $urandom, 1'b1);
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) miss("fill_idle");
        chk("fill_out_valid", 64'(bus.out_valid), 64'd1);
        chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        @(posedge clk);
        #1;
        rdy_mode = 0;
        @(negedge clk);
        chk("fill_pop_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        rdy_mode = 2;

        // randomized traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       d = int'($urandom_range(1, TO));
            else if (r == 7) d = TO;
            else if (r == 8) d = TO + 1;
            else             d = 0;
            a = $urandom;
            send(a, d, a ^ 32'hA5C3_5A3C, 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end

        rdy_mode = 1;
        n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) miss("drain");
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("end_err_count", 64'(bus.err_count),
            64'((n_to > 255) ? 255 : n_to));
        chk("end_out_valid", 64'(bus.out_valid), 64'd0);
        chk("end_busy", 64'(bus.busy), 64'd0);
        chk("end_jobs", 64'(jobs.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/sincos_requester.md
SINCOS_REQUESTER -- requirements
Module: sincos_requester

Interface
REQ-001 Parameter: DEPTH, 4, result FIFO entries (power of two, 2..16).
REQ-002 Parameter: TIMEOUT, 64, max WAIT cycles before abandoning a request.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  in  1  upstream angle request valid.
REQ-006 Port: in_opx  in  32  IEEE-754 single angle, radians.
REQ-007 Port: in_ready  out  1  request accepted when in_valid && in_ready.
REQ-008 Port: sine_start  out  1  one-cycle start pulse to sincos engine.
REQ-009 Port: opx  out  32  operand to engine.
REQ-010 Port: sine_done  in  1  engine completion pulse.
REQ-011 Port: sine_result  in  32  engine result, valid with sine_done.
REQ-012 Port: out_valid  out  1  result FIFO non-empty.
REQ-013 Port: out_ready  in  1  downstream pop when out_valid && out_ready.
REQ-014 Port: out_result  out  32  FIFO head result.
REQ-015 Port: out_err  out  1  FIFO head entry produced by timeout.
REQ-016 Port: busy  out  1  high in ISSUE or WAIT.
REQ-017 Port: err_count  out  8  timeouts since reset, saturating at 255.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT; one request outstanding at most.
REQ-019 in_ready = (state==IDLE) && (fifo_count < DEPTH) && !rst; combinational.
REQ-020 IDLE with accept: latch in_opx into opx, go ISSUE next cycle.
REQ-021 ISSUE: sine_start=1 exactly one cycle, timer loaded 0, go WAIT.
REQ-022 opx held stable from ISSUE through end of WAIT; changes only on next accept.
REQ-023 WAIT with sine_done: push {err=0, sine_result}, go IDLE.
REQ-024 WAIT, timer reaches TIMEOUT-1 without sine_done: push {err=1, 32'h7FC00000}, err_count+1 (saturating), go IDLE.
REQ-025 sine_done and timeout in same cycle: sine_done wins, no error.
REQ-026 sine_done in IDLE or ISSUE ignored, no push, no state change.
REQ-027 Space reserved at accept; push never occurs when FIFO full; no overflow possible.
REQ-028 FIFO first-in first-out; out_result/out_err valid whenever out_valid=1.
REQ-029 Simultaneous push and pop: both occur, count unchanged; pop when empty ignored.
REQ-030 Pointers wrap modulo DEPTH; fifo_count range 0..DEPTH.
REQ-031 Latency: accept at cycle t -> sine_start at t+1; sine_done at t+k -> out_valid at t+k+1 (FIFO previously empty).
REQ-032 Back-to-back: next accept earliest the cycle after push (IDLE), sine_start one cycle later.

Reset
REQ-033 rst high at clk edge: state IDLE, FIFO empty, timer 0, err_count 0, opx 0.
REQ-034 During/after reset: sine_start=0, in_ready=0 while rst, out_valid=0, out_result=0, out_err=0, busy=0.
REQ-035 Reset mid-WAIT abandons request; later sine_done for it ignored (IDLE).

Verification
REQ-036 Single request: in_opx=32'h3FC90FDB accepted t, sine_done at t+5 with 32'h3F800000 -> sine_start t+1 only, opx stable, out_valid t+6, out_result 32'h3F800000, out_err 0.
REQ-037 Fill: out_ready=0, 4 requests all completed -> out_valid=1, count 4, in_ready=0 while in IDLE; one pop -> in_ready returns next cycle.
REQ-038 Timeout: TIMEOUT=64, no sine_done -> push at 64th WAIT cycle, out_result 32'h7FC00000, out_err 1, err_count 1; late sine_done ignored.
REQ-039 Done/timeout collision: sine_done on final WAIT cycle with 32'h3F000000 -> out_err 0, err_count unchanged.
REQ-040 Reset in WAIT: rst pulse then sine_done -> FIFO stays empty, busy 0, err_count 0.
REQ-041 Concurrent push/pop at count 2 -> count 2, order preserved across pointer wrap (8 sequential values).
